reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Parametrised register-busy scoreboard. It succeeds the fixed two-port busy table used by the schedule stage. The scheduler marks destination registers busy at issue, and commit/writeback frees them. The scheduler queries source and destination registers through query ports to detect RAW/WAW hazards. It generalises register count, set/free/query port counts, and tracks the owning execution unit per register.

Parameters:
NUM_REGS, 64, number of architectural registers (power of two, >=2)
RN_W, 6, register number width, equal to log2(NUM_REGS)
UNIT_W, 3, execution-unit tag width
SET_PORTS, 2, number of busy-set (issue) ports
FREE_PORTS, 2, number of free (writeback) ports
QRY_PORTS, 4, number of hazard query ports

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all busy state
set_en  in  SET_PORTS  per-port set strobe
set_rn  in  SET_PORTS*RN_W  register to mark busy; port i occupies bits [i*RN_W +: RN_W]
set_unit  in  SET_PORTS*UNIT_W  owning unit tag, packed the same way
free_en  in  FREE_PORTS  per-port free strobe
free_rn  in  FREE_PORTS*RN_W  register to free, packed
q_rn  in  QRY_PORTS*RN_W  query register numbers, packed
q_busy  out  QRY_PORTS  busy status of each queried register
q_unit  out  QRY_PORTS*UNIT_W  owner tag of each queried register (0 if not busy)
reg_busy  out  NUM_REGS  full busy vector; bit n = register n
busy_count  out  RN_W+1  number of busy registers (registered)
err_double_set  out  1  sticky: set targeted an already-busy register, or two set ports hit the same register in one cycle
err_free_idle  out  1  sticky: free targeted a non-busy register

Behaviour:
- Reset (async, rst_n=0): all busy bits 0, all owner tags 0, busy_count 0, both error flags 0. q_busy and q_unit therefore read 0. Reset asserted mid-operation discards all state immediately.
- Register 0 is hardwired not busy. Sets and frees of rn 0 are ignored and never raise an error.
- State per register: busy bit and UNIT_W owner tag. It updates on the rising clk edge.
- Set: set_en[i] marks set_rn[i] busy and loads its owner from set_unit[i]. The new state is visible the cycle after the strobe (1-cycle latency).
- Free: free_en[j] clears the busy bit of free_rn[j] and zeroes its owner tag. Latency is 1 cycle.
- Simultaneous set and free of the same register: set wins. The register stays/becomes busy with the new owner, and no error is raised.
- Two set ports targeting the same register in the same cycle: the highest-index port's tag wins, and err_double_set is raised.
- Set of a register already busy, and not freed in that cycle: the owner is overwritten and err_double_set is raised.
- Multiple free ports targeting the same register: a single free, with no error.
- Free of a register that is not busy and not being set in that cycle: no state change, and err_free_idle is raised.
- Priority: flush > set > free. Flush clears all busy bits, tags and busy_count in one cycle, and ignores same-cycle set/free. Error flags are unaffected by flush.
- Error flags are sticky until reset.
- Query ports are purely combinational from registered state: q_busy[k] = busy[q_rn[k]], and q_unit[k] = its owner tag.
- busy_count is registered and computed from next-state. It always equals the popcount of reg_busy in the same cycle and never exceeds NUM_REGS-1.
- No internal stall. Hazard resolution is the scheduler's responsibility.

Optional Feature:
SCB_BYPASS_EN.
- Defined: the query path forwards same-cycle frees. If any free_en[j] has free_rn[j]==q_rn[k], and no same-cycle set targets that register, then q_busy[k]=0 and q_unit[k]=0 in that cycle. This lets the scheduler issue a dependent instruction one cycle earlier. reg_busy and busy_count remain registered-only.
- Undefined: queries reflect registered state only, and a freed register reads not-busy one cycle after the free.

Test Plan:
- Reset, then set_en[0]=1, set_rn[0]=5, set_unit[0]=2. Next cycle: q_rn[0]=5 gives q_busy[0]=1, q_unit[0]=2; reg_busy[5]=1; busy_count=1.
- Reg 5 busy, free_en[1]=1, free_rn[1]=5 -> without bypass, q_busy=1 during the free cycle and 0 the following cycle; with SCB_BYPASS_EN, q_busy=0 during the free cycle. busy_count returns to 0.
- Same cycle: set rn 9 with unit 4 and free rn 9 -> next cycle reg_busy[9]=1, owner 4, no error flags.
- set_rn[0]=set_rn[1]=7 with units 1 and 3 -> owner 3, err_double_set=1, and it stays 1 after a later flush.
- Free rn 12 while idle -> err_free_idle=1, reg_busy unchanged. Set rn 0 -> reg_busy[0] stays 0, no error.
- Registers 1..63 set over successive cycles -> busy_count=63. Assert flush together with set of rn 3 -> next cycle reg_busy=0, busy_count=0. Drop rst_n mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: per-register busy bit and owner tag, set at issue, freed at writeback.
// Optional SCB_BYPASS_EN forwards same-cycle frees onto the query ports.
module reg_scoreboard #(
    parameter int NUM_REGS   = 64,
    parameter int RN_W       = 6,
    parameter int UNIT_W     = 3,
    parameter int SET_PORTS  = 2,
    parameter int FREE_PORTS = 2,
    parameter int QRY_PORTS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [SET_PORTS-1:0]         set_en,
    input  logic [SET_PORTS*RN_W-1:0]    set_rn,
    input  logic [SET_PORTS*UNIT_W-1:0]  set_unit,
    input  logic [FREE_PORTS-1:0]        free_en,
    input  logic [FREE_PORTS*RN_W-1:0]   free_rn,
    input  logic [QRY_PORTS*RN_W-1:0]    q_rn,
    output logic [QRY_PORTS-1:0]         q_busy,
    output logic [QRY_PORTS*UNIT_W-1:0]  q_unit,
    output logic [NUM_REGS-1:0]          reg_busy,
    output logic [RN_W:0]                busy_count,
    output logic                         err_double_set,
    output logic                         err_free_idle
);

    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [NUM_REGS-1:0][UNIT_W-1:0] owner_q, owner_d;
    logic [RN_W:0]                   count_q, count_d;
    logic                            err_ds_q, err_ds_d;
    logic                            err_fi_q, err_fi_d;

    logic [NUM_REGS-1:0]             set_hit, set_multi, free_hit;
    logic [NUM_REGS-1:0][UNIT_W-1:0] set_tag;

    // Per-register decode of the strobe ports; later ports overwrite the tag so the highest index wins.
    always_comb begin : decode
        set_hit   = '0;
        set_multi = '0;
        free_hit  = '0;
        set_tag   = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int i = 0; i < SET_PORTS; i++) begin
                if (set_en[i] && set_rn[i*RN_W +: RN_W] == RN_W'(r)) begin
                    if (set_hit[r])
                        set_multi[r] = 1'b1;
                    set_hit[r] = 1'b1;
                    set_tag[r] = set_unit[i*UNIT_W +: UNIT_W];
                end
            end
            for (int j = 0; j < FREE_PORTS; j++) begin
                if (free_en[j] && free_rn[j*RN_W +: RN_W] == RN_W'(r))
                    free_hit[r] = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        busy_d   = busy_q;
        owner_d  = owner_q;
        err_ds_d = err_ds_q;
        err_fi_d = err_fi_q;
        count_d  = '0;
        if (flush) begin
            busy_d  = '0;
            owner_d = '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (set_hit[r]) begin
                    busy_d[r]  = 1'b1;
                    owner_d[r] = set_tag[r];
                    if (set_multi[r] || (busy_q[r] && !free_hit[r]))
                        err_ds_d = 1'b1;
                end else if (free_hit[r]) begin
                    busy_d[r]  = 1'b0;
                    owner_d[r] = '0;
                    if (!busy_q[r])
                        err_fi_d = 1'b1;
                end
            end
        end
        // Count from next-state so the registered count tracks reg_busy cycle for cycle.
        for (int r = 0; r < NUM_REGS; r++)
            count_d = count_d + (RN_W+1)'(busy_d[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            owner_q  <= '0;
            count_q  <= '0;
            err_ds_q <= 1'b0;
            err_fi_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            err_ds_q <= err_ds_d;
            err_fi_q <= err_fi_d;
        end
    end

`ifdef SCB_BYPASS_EN
    logic byp_free, byp_set;
`endif

    always_comb begin : query
        q_busy = '0;
        q_unit = '0;
`ifdef SCB_BYPASS_EN
        byp_free = 1'b0;
        byp_set  = 1'b0;
`endif
        for (int k = 0; k < QRY_PORTS; k++) begin
            q_busy[k]                  = busy_q[q_rn[k*RN_W +: RN_W]];
            q_unit[k*UNIT_W +: UNIT_W] = owner_q[q_rn[k*RN_W +: RN_W]];
`ifdef SCB_BYPASS_EN
            byp_free = 1'b0;
            byp_set  = 1'b0;
            for (int j = 0; j < FREE_PORTS; j++)
                if (free_en[j] && free_rn[j*RN_W +: RN_W] == q_rn[k*RN_W +: RN_W])
                    byp_free = 1'b1;
            for (int i = 0; i < SET_PORTS; i++)
                if (set_en[i] && set_rn[i*RN_W +: RN_W] == q_rn[k*RN_W +: RN_W])
                    byp_set = 1'b1;
            // A set in the same cycle keeps the register busy, so only unopposed frees forward.
            if (byp_free && !byp_set) begin
                q_busy[k]                  = 1'b0;
                q_unit[k*UNIT_W +: UNIT_W] = '0;
            end
`endif
        end
    end

    assign reg_busy       = busy_q;
    assign busy_count     = count_q;
    assign err_double_set = err_ds_q;
    assign err_free_idle  = err_fi_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: vector table, corner-case sequences, randomized run vs. a model.
module tb_reg_scoreboard;
    localparam int NR = 64, RW = 6, UW = 3, SP = 2, FP = 2, QP = 4;

    logic              clk, rst_n, flush;
    logic [SP-1:0]     set_en;
    logic [SP*RW-1:0]  set_rn;
    logic [SP*UW-1:0]  set_unit;
    logic [FP-1:0]     free_en;
    logic [FP*RW-1:0]  free_rn;
    logic [QP*RW-1:0]  q_rn;
    logic [QP-1:0]     q_busy;
    logic [QP*UW-1:0]  q_unit;
    logic [NR-1:0]     reg_busy;
    logic [RW:0]       busy_count;
    logic              err_double_set, err_free_idle;

    reg_scoreboard #(.NUM_REGS(NR), .RN_W(RW), .UNIT_W(UW), .SET_PORTS(SP),
                     .FREE_PORTS(FP), .QRY_PORTS(QP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .set_en(set_en), .set_rn(set_rn), .set_unit(set_unit),
        .free_en(free_en), .free_rn(free_rn), .q_rn(q_rn),
        .q_busy(q_busy), .q_unit(q_unit), .reg_busy(reg_busy), .busy_count(busy_count),
        .err_double_set(err_double_set), .err_free_idle(err_free_idle));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays holding register state as the rules describe it.
    bit m_busy[NR];
    int m_own[NR];
    bit m_ds, m_fi;

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin m_busy[r] = 0; m_own[r] = 0; end
        m_ds = 0; m_fi = 0;
    endtask

    function automatic bit is_freed(int rn);
        for (int j = 0; j < FP; j++)
            if (free_en[j] && int'(free_rn[j*RW +: RW]) == rn) return 1;
        return 0;
    endfunction

    function automatic bit is_set(int rn);
        for (int i = 0; i < SP; i++)
            if (set_en[i] && int'(set_rn[i*RW +: RW]) == rn) return 1;
        return 0;
    endfunction

    task automatic model_step();
        bit nb[NR];
        int no[NR];
        bit seen[NR];
        if (flush) begin
            for (int r = 0; r < NR; r++) begin m_busy[r] = 0; m_own[r] = 0; end
            return;
        end
        for (int r = 0; r < NR; r++) begin nb[r] = m_busy[r]; no[r] = m_own[r]; seen[r] = 0; end
        for (int r = 1; r < NR; r++)
            if (is_freed(r) && !is_set(r)) begin
                if (!m_busy[r]) m_fi = 1;
                nb[r] = 0; no[r] = 0;
            end
        for (int i = 0; i < SP; i++) begin
            int rn;
            rn = int'(set_rn[i*RW +: RW]);
            if (set_en[i] && rn != 0) begin
                if (seen[rn] || (m_busy[rn] && !is_freed(rn))) m_ds = 1;
                seen[rn] = 1;
                nb[rn] = 1;
                no[rn] = int'(set_unit[i*UW +: UW]);
            end
        end
        for (int r = 0; r < NR; r++) begin m_busy[r] = nb[r]; m_own[r] = no[r]; end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] vec;
        int cnt;
        cnt = 0;
        vec = '0;
        for (int r = 0; r < NR; r++) begin vec[r] = m_busy[r]; cnt += int'(m_busy[r]); end
        chk({tag, " reg_busy"}, reg_busy, vec);
        chk({tag, " busy_count"}, 64'(busy_count), 64'(cnt));
        chk({tag, " err_double_set"}, 64'(err_double_set), 64'(m_ds));
        chk({tag, " err_free_idle"}, 64'(err_free_idle), 64'(m_fi));
        for (int k = 0; k < QP; k++) begin
            int rn, eb, eu;
            rn = int'(q_rn[k*RW +: RW]);
            eb = int'(m_busy[rn]);
            eu = m_own[rn];
`ifdef SCB_BYPASS_EN
            if (is_freed(rn) && !is_set(rn)) begin eb = 0; eu = 0; end
`endif
            chk({tag, " q_busy"}, 64'(q_busy[k]), 64'(eb));
            chk({tag, " q_unit"}, 64'(q_unit[k*UW +: UW]), 64'(eu));
        end
    endtask

    task automatic idle();
        flush = 0; set_en = '0; set_rn = '0; set_unit = '0;
        free_en = '0; free_rn = '0; q_rn = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0] se; logic [5:0] sr0, sr1; logic [2:0] su0, su1;
        logic [1:0] fe; logic [5:0] fr0, fr1; logic fl;
        logic [5:0] qr; logic eb; logic [2:0] eu; int ecnt; logic eds, efi;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic [1:0] se, logic [5:0] sr0, logic [2:0] su0,
                                logic [5:0] sr1, logic [2:0] su1,
                                logic [1:0] fe, logic [5:0] fr0, logic [5:0] fr1, logic fl,
                                logic [5:0] qr, logic eb, logic [2:0] eu, int ecnt,
                                logic eds, logic efi);
        vec_t v;
        v.se = se; v.sr0 = sr0; v.su0 = su0; v.sr1 = sr1; v.su1 = su1;
        v.fe = fe; v.fr0 = fr0; v.fr1 = fr1; v.fl = fl;
        v.qr = qr; v.eb = eb; v.eu = eu; v.ecnt = ecnt; v.eds = eds; v.efi = efi;
        return v;
    endfunction

    initial begin
        //            se     sr0 su0 sr1 su1 fe     fr0 fr1 fl  qr  eb eu cnt ds fi
        tbl[0]  = mk(2'b01,  5, 2,  0, 0, 2'b00,  0,  0, 0,  5, 1, 2, 1, 0, 0); // set 5
        tbl[1]  = mk(2'b01,  9, 4,  0, 0, 2'b01,  9,  0, 0,  9, 1, 4, 2, 0, 0); // set+free 9
        tbl[2]  = mk(2'b00,  0, 0,  0, 0, 2'b10,  0,  5, 0,  5, 0, 0, 1, 0, 0); // free 5 port1
        tbl[3]  = mk(2'b01,  0, 5,  0, 0, 2'b00,  0,  0, 0,  0, 0, 0, 1, 0, 0); // set rn0
        tbl[4]  = mk(2'b00,  0, 0,  0, 0, 2'b01,  0,  0, 0,  0, 0, 0, 1, 0, 0); // free rn0
        tbl[5]  = mk(2'b00,  0, 0,  0, 0, 2'b11,  9,  9, 0,  9, 0, 0, 0, 0, 0); // double free
        tbl[6]  = mk(2'b10,  0, 0, 20, 6, 2'b00,  0,  0, 0, 20, 1, 6, 1, 0, 0); // set 20 port1
        tbl[7]  = mk(2'b01, 20, 3,  0, 0, 2'b10,  0, 20, 0, 20, 1, 3, 1, 0, 0); // reset owner via free
        tbl[8]  = mk(2'b00,  0, 0,  0, 0, 2'b01, 12,  0, 0, 12, 0, 0, 1, 0, 1); // free idle 12
        tbl[9]  = mk(2'b11,  7, 1,  7, 3, 2'b00,  0,  0, 0,  7, 1, 3, 2, 1, 1); // dual set 7
        tbl[10] = mk(2'b01,  3, 5,  0, 0, 2'b00,  0,  0, 1,  3, 0, 0, 0, 1, 1); // flush wins
        tbl[11] = mk(2'b01, 30, 5,  0, 0, 2'b00,  0,  0, 0, 30, 1, 5, 1, 1, 1);
        tbl[12] = mk(2'b01, 30, 2,  0, 0, 2'b00,  0,  0, 0, 30, 1, 2, 1, 1, 1); // overwrite busy

        rst_n = 1;
        idle();
        #2;
        rst_n = 0;
        #2;
        chk("reset reg_busy", reg_busy, 64'h0);
        chk("reset busy_count", 64'(busy_count), 64'h0);
        chk("reset q_busy", 64'(q_busy), 64'h0);
        chk("reset q_unit", 64'(q_unit), 64'h0);
        chk("reset errs", {62'h0, err_double_set, err_free_idle}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1;

        for (int v = 0; v < 13; v++) begin
            flush = tbl[v].fl;
            set_en = tbl[v].se;
            set_rn = {tbl[v].sr1, tbl[v].sr0};
            set_unit = {tbl[v].su1, tbl[v].su0};
            free_en = tbl[v].fe;
            free_rn = {tbl[v].fr1, tbl[v].fr0};
            @(posedge clk); #1;
            idle();
            q_rn[5:0] = tbl[v].qr;
            #1;
            chk($sformatf("vec%0d q_busy", v), 64'(q_busy[0]), 64'(tbl[v].eb));
            chk($sformatf("vec%0d q_unit", v), 64'(q_unit[2:0]), 64'(tbl[v].eu));
            chk($sformatf("vec%0d reg_busy_bit", v), 64'(reg_busy[tbl[v].qr]), 64'(tbl[v].eb));
            chk($sformatf("vec%0d busy_count", v), 64'(busy_count), 64'(tbl[v].ecnt));
            chk($sformatf("vec%0d err_double_set", v), 64'(err_double_set), 64'(tbl[v].eds));
            chk($sformatf("vec%0d err_free_idle", v), 64'(err_free_idle), 64'(tbl[v].efi));
        end

        // Free timing of the query path.
        do_reset();
        set_en = 2'b01; set_rn[5:0] = 6'd5; set_unit[2:0] = 3'd2;
        @(posedge clk); #1;
        idle();
        free_en = 2'b10; free_rn[11:6] = 6'd5; q_rn[5:0] = 6'd5;
        #1;
`ifdef SCB_BYPASS_EN
        chk("free-cycle q_busy", 64'(q_busy[0]), 64'h0);
        chk("free-cycle q_unit", 64'(q_unit[2:0]), 64'h0);
`else
        chk("free-cycle q_busy", 64'(q_busy[0]), 64'h1);
        chk("free-cycle q_unit", 64'(q_unit[2:0]), 64'h2);
`endif
        chk("free-cycle reg_busy", reg_busy, 64'h20);
        chk("free-cycle busy_count", 64'(busy_count), 64'h1);
        @(posedge clk); #1;
        idle();
        q_rn[5:0] = 6'd5;
        #1;
        chk("after-free q_busy", 64'(q_busy[0]), 64'h0);
        chk("after-free busy_count", 64'(busy_count), 64'h0);

        // Fill every register, then flush against a concurrent set.
        do_reset();
        for (int r = 1; r < NR; r++) begin
            set_en = 2'b01; set_rn[5:0] = 6'(r); set_unit[2:0] = 3'(r);
            @(posedge clk); #1;
        end
        idle();
        #1;
        chk("full busy_count", 64'(busy_count), 64'd63);
        chk("full reg_busy", reg_busy, ~64'h1);
        chk("full no err", {62'h0, err_double_set, err_free_idle}, 64'h0);
        flush = 1; set_en = 2'b01; set_rn[5:0] = 6'd3; set_unit[2:0] = 3'd1;
        @(posedge clk); #1;
        idle();
        #1;
        chk("flush reg_busy", reg_busy, 64'h0);
        chk("flush busy_count", 64'(busy_count), 64'h0);

        // Asynchronous reset in the middle of a cycle.
        set_en = 2'b11; set_rn = {6'd8, 6'd4}; set_unit = {3'd7, 3'd6};
        free_en = 2'b01; free_rn[5:0] = 6'd12;
        @(posedge clk); #1;
        idle();
        q_rn = {6'd8, 6'd4, 6'd8, 6'd4};
        #1;
        chk("pre-rst q_busy", 64'(q_busy), 64'hF);
        chk("pre-rst err_free_idle", 64'(err_free_idle), 64'h1);
        #1;
        rst_n = 0;
        #1;
        chk("mid-rst reg_busy", reg_busy, 64'h0);
        chk("mid-rst busy_count", 64'(busy_count), 64'h0);
        chk("mid-rst q_busy", 64'(q_busy), 64'h0);
        chk("mid-rst q_unit", 64'(q_unit), 64'h0);
        chk("mid-rst errs", {62'h0, err_double_set, err_free_idle}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();

        // Randomized traffic on a narrow register range to force collisions.
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 249) begin
                do_reset();
            end
            flush = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < SP; i++) begin
                set_en[i] = ($urandom_range(0, 2) == 0);
                set_rn[i*RW +: RW] = 6'($urandom_range(0, 15));
                set_unit[i*UW +: UW] = 3'($urandom_range(0, 7));
            end
            for (int j = 0; j < FP; j++) begin
                free_en[j] = ($urandom_range(0, 2) == 0);
                free_rn[j*RW +: RW] = 6'($urandom_range(0, 15));
            end
            for (int k = 0; k < QP; k++)
                q_rn[k*RW +: RW] = 6'($urandom_range(0, 15));
            #1;
            check_model($sformatf("rand%0d", c));
            @(posedge clk);
            model_step();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
